// File: rtl/button_pio_in_if.sv
// rtl/button_pio_in_if.sv - Avalon-MM slave bus bundle for the button input PIO
//
// Signals:
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data (32 bits)
//   readdata   read data, combinational from address (32 bits)
// Modports: master drives the request side, slave drives readdata.

interface button_pio_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/button_pio_in.sv
// rtl/button_pio_in.sv - Avalon-MM input PIO with sync, optional debounce, edge capture and irq
//
// Purpose: per-bit two-flop synchronizer, optional debounce, edge detect,
//   write-1-to-clear edge-capture register and a maskable level interrupt.
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN (per-bit debounce counters).
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      button_pio_in_if.slave (address/chipselect/write_n/writedata/readdata)
//   in_port  asynchronous external inputs, WIDTH bits
//   irq      level interrupt, active high
// Register map: 0 DATA (RO), 2 IRQ_MASK (RW), 3 EDGE_CAP (W1C), others read 0.

module button_pio_in #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 1,
    parameter int RESET_LEVEL     = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_pio_in_if.slave       bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [WIDTH-1:0] RST_VAL = (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise, fall, edge_v, clr;
    logic             wr_en;
    logic [31:0]      rdata;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata are meaningful.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A bit must disagree with deb for DEBOUNCE_CYCLES consecutive cycles
    // before deb follows; any agreeing cycle restarts the window.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_q <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign deb = deb_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign deb = sync2_q;
`endif

    // Edge detect against the one-cycle delayed debounced value; both
    // reset to the same level so nothing fires right after reset.
    always_comb begin
        deb_dly_d = deb;
        rise      = deb & ~deb_dly_q;
        fall      = ~deb & deb_dly_q;
        case (EDGE_TYPE)
            0:       edge_v = rise;
            1:       edge_v = fall;
            default: edge_v = rise | fall;
        endcase
    end

    // Register writes; a new edge beats a same-cycle W1C on that bit.
    always_comb begin
        wr_en      = bus.chipselect & ~bus.write_n;
        clr        = '0;
        irq_mask_d = irq_mask_q;
        if (wr_en && bus.address == 3'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == 3'd2) begin
            irq_mask_d = bus.writedata[WIDTH-1:0];
        end
        edge_cap_d = (edge_cap_q & ~clr) | edge_v;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= RST_VAL;
            sync2_q    <= RST_VAL;
            deb_dly_q  <= RST_VAL;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_dly_q  <= deb_dly_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    // Zero-latency read mux, no side effects, chipselect not required.
    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd0:    rdata[WIDTH-1:0] = deb;
            3'd2:    rdata[WIDTH-1:0] = irq_mask_q;
            3'd3:    rdata[WIDTH-1:0] = edge_cap_q;
            default: rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_button_pio_in.sv
// tb/tb_button_pio_in.sv - directed bench for button_pio_in (falling-edge and any-edge instances)

module tb_button_pio_in;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_port;
    logic        irq_f, irq_a;
    logic [31:0] rd_f, rd_a;
    int          tests_run;
    int          tests_failed;

    button_pio_in_if bus_f ();
    button_pio_in_if bus_a ();

    button_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .RESET_LEVEL(1), .DEBOUNCE_CYCLES(4)) u_fall (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_f),
        .in_port (in_port),
        .irq     (irq_f)
    );

    button_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .RESET_LEVEL(1), .DEBOUNCE_CYCLES(4)) u_any (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a),
        .in_port (in_port),
        .irq     (irq_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus_f.address = addr; bus_f.writedata = data; bus_f.chipselect = 1'b1; bus_f.write_n = 1'b0;
        bus_a.address = addr; bus_a.writedata = data; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        step(1);
        bus_f.chipselect = 1'b0; bus_f.write_n = 1'b1;
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] addr);
        bus_f.address = addr;
        bus_a.address = addr;
        #1;
        rd_f = bus_f.readdata;
        rd_a = bus_a.readdata;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_port = 8'hFF;
        step(3);
        reset_n = 1'b1;
        step(10);
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFF) begin tests_failed++; $display("FAIL reset_data_f act=%h exp=%h", rd_f, 32'hFF); end
        tests_run++; if (rd_a !== 32'hFF) begin tests_failed++; $display("FAIL reset_data_a act=%h exp=%h", rd_a, 32'hFF); end
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL reset_ecap_f act=%h exp=%h", rd_f, 32'h0); end
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL reset_ecap_a act=%h exp=%h", rd_a, 32'h0); end
        rd(3'd2);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL reset_mask act=%h exp=%h", rd_f, 32'h0); end
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL reset_irq act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
    endtask

    task automatic test_register_map;
        wr(3'd0, 32'h0);
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFF) begin tests_failed++; $display("FAIL data_ro act=%h exp=%h", rd_f, 32'hFF); end
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL addr1_zero act=%h exp=%h", rd_f, 32'h0); end
        rd(3'd5);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL addr5_zero act=%h exp=%h", rd_a, 32'h0); end
        wr(3'd2, 32'hFFFF_FFA5);
        rd(3'd2);
        tests_run++; if (rd_f !== 32'hA5) begin tests_failed++; $display("FAIL mask_rw act=%h exp=%h", rd_f, 32'hA5); end
        // write strobe without chipselect must be ignored
        bus_f.address = 3'd2; bus_f.writedata = 32'h0; bus_f.write_n = 1'b0; bus_f.chipselect = 1'b0;
        step(1);
        bus_f.write_n = 1'b1;
        rd(3'd2);
        tests_run++; if (rd_f !== 32'hA5) begin tests_failed++; $display("FAIL mask_no_cs act=%h exp=%h", rd_f, 32'hA5); end
        wr(3'd2, 32'h0);
        rd(3'd2);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL mask_clear act=%h exp=%h", rd_a, 32'h0); end
    endtask

    task automatic test_falling_edge;
        in_port = 8'hFB;
        step(D + 1);
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFF) begin tests_failed++; $display("FAIL fall_data_early act=%h exp=%h", rd_f, 32'hFF); end
        step(1);
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFB) begin tests_failed++; $display("FAIL fall_data act=%h exp=%h", rd_f, 32'hFB); end
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL fall_ecap_early act=%h exp=%h", rd_f, 32'h0); end
        step(1);
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h04) begin tests_failed++; $display("FAIL fall_ecap_f act=%h exp=%h", rd_f, 32'h04); end
        tests_run++; if (rd_a !== 32'h04) begin tests_failed++; $display("FAIL fall_ecap_a act=%h exp=%h", rd_a, 32'h04); end
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL fall_irq_masked act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
        wr(3'd2, 32'h04);
        tests_run++; if ({irq_f, irq_a} !== 2'b11) begin tests_failed++; $display("FAIL fall_irq_unmask act=%b exp=%b", {irq_f, irq_a}, 2'b11); end
        wr(3'd3, 32'h04);
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL fall_irq_clr act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
        in_port = 8'hFF;
        step(D + 3);
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL rise_ignored_f act=%h exp=%h", rd_f, 32'h0); end
        tests_run++; if (rd_a !== 32'h04) begin tests_failed++; $display("FAIL rise_any_a act=%h exp=%h", rd_a, 32'h04); end
        tests_run++; if ({irq_f, irq_a} !== 2'b01) begin tests_failed++; $display("FAIL rise_irq act=%b exp=%b", {irq_f, irq_a}, 2'b01); end
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_glitch_filter;
        logic [31:0] exp_cap;
        exp_cap = (D == 0) ? 32'h01 : 32'h0;
        in_port = 8'hFE;
        step(3);
        in_port = 8'hFF;
        step(D + 4);
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFF) begin tests_failed++; $display("FAIL glitch_data act=%h exp=%h", rd_f, 32'hFF); end
        rd(3'd3);
        tests_run++; if (rd_f !== exp_cap) begin tests_failed++; $display("FAIL glitch_ecap_f act=%h exp=%h", rd_f, exp_cap); end
        tests_run++; if (rd_a !== exp_cap) begin tests_failed++; $display("FAIL glitch_ecap_a act=%h exp=%h", rd_a, exp_cap); end
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_w1c;
        wr(3'd2, 32'hFF);
        in_port = 8'hFA;
        step(D + 3);
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h05) begin tests_failed++; $display("FAIL w1c_pre act=%h exp=%h", rd_f, 32'h05); end
        wr(3'd3, 32'h01);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h04) begin tests_failed++; $display("FAIL w1c_bit0 act=%h exp=%h", rd_a, 32'h04); end
        tests_run++; if ({irq_f, irq_a} !== 2'b11) begin tests_failed++; $display("FAIL w1c_irq_held act=%b exp=%b", {irq_f, irq_a}, 2'b11); end
        wr(3'd3, 32'h04);
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL w1c_all act=%h exp=%h", rd_f, 32'h0); end
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL w1c_irq_drop act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
        in_port = 8'hFF;
        step(D + 3);
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_set_clear_collision;
        in_port = 8'hFD;
        step(D + 3);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h02) begin tests_failed++; $display("FAIL coll_pre act=%h exp=%h", rd_a, 32'h02); end
        in_port = 8'hFF;
        step(D + 2);
        // this write lands on the same edge that captures the rising edge
        wr(3'd3, 32'h02);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h02) begin tests_failed++; $display("FAIL coll_set_wins act=%h exp=%h", rd_a, 32'h02); end
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL coll_clr_f act=%h exp=%h", rd_f, 32'h0); end
        tests_run++; if ({irq_f, irq_a} !== 2'b01) begin tests_failed++; $display("FAIL coll_irq act=%b exp=%b", {irq_f, irq_a}, 2'b01); end
        wr(3'd3, 32'hFF);
    endtask

    task automatic test_any_edge_and_reset;
        in_port = 8'h7F;
        step(D + 2);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL b7_fall_early act=%h exp=%h", rd_a, 32'h0); end
        step(1);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h80) begin tests_failed++; $display("FAIL b7_fall_a act=%h exp=%h", rd_a, 32'h80); end
        tests_run++; if (rd_f !== 32'h80) begin tests_failed++; $display("FAIL b7_fall_f act=%h exp=%h", rd_f, 32'h80); end
        wr(3'd3, 32'h80);
        in_port = 8'hFF;
        step(D + 2);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL b7_rise_early act=%h exp=%h", rd_a, 32'h0); end
        step(1);
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h80) begin tests_failed++; $display("FAIL b7_rise_a act=%h exp=%h", rd_a, 32'h80); end
        tests_run++; if (rd_f !== 32'h0) begin tests_failed++; $display("FAIL b7_rise_f act=%h exp=%h", rd_f, 32'h0); end
        in_port = 8'h7F;
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        rd(3'd2);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL rst_mask act=%h exp=%h", rd_a, 32'h0); end
        rd(3'd3);
        tests_run++; if (rd_a !== 32'h0) begin tests_failed++; $display("FAIL rst_ecap act=%h exp=%h", rd_a, 32'h0); end
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL rst_irq act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
        rd(3'd0);
        tests_run++; if (rd_f !== 32'hFF) begin tests_failed++; $display("FAIL rst_data act=%h exp=%h", rd_f, 32'hFF); end
        step(D + 4);
        rd(3'd3);
        tests_run++; if (rd_f !== 32'h80) begin tests_failed++; $display("FAIL post_rst_ecap act=%h exp=%h", rd_f, 32'h80); end
        tests_run++; if ({irq_f, irq_a} !== 2'b00) begin tests_failed++; $display("FAIL post_rst_irq act=%b exp=%b", {irq_f, irq_a}, 2'b00); end
        rd(3'd0);
        tests_run++; if (rd_a !== 32'h7F) begin tests_failed++; $display("FAIL post_rst_data act=%h exp=%h", rd_a, 32'h7F); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        in_port      = 8'hFF;
        bus_f.address = 3'd0; bus_f.chipselect = 1'b0; bus_f.write_n = 1'b1; bus_f.writedata = 32'h0;
        bus_a.address = 3'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = 32'h0;
        test_reset();
        test_register_map();
        test_falling_edge();
        test_glitch_filter();
        test_w1c();
        test_set_clear_collision();
        test_any_edge_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/button_pio_in.md
Name: button_pio_in

Overview:
- Avalon-MM slave input PIO. The push-button and switch inputs enter through this block. It is the read-side counterpart of the existing output PIO.
- Per bit: synchronizes the external inputs, optionally debounces them, detects edges, latches them in an edge-capture register and raises a maskable level interrupt to the Nios II.
- Connects to the system interconnect as a zero-wait-state slave, with irq routed to the CPU interrupt controller.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 1, edge that sets a capture bit: 0 rising, 1 falling, 2 any.
- RESET_LEVEL, 1, reset value of the synchronizer, debounced and delayed registers (buttons idle high).
- DEBOUNCE_CYCLES, 50000, stability window in clk cycles (>=1). Used only with BUTTON_PIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, combinational from address (read latency 0); upper bits zero.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: one clock, synchronous, active-low. Sampled on a clk rising edge with reset_n=0.
  - Sync, debounced and delayed registers go to {WIDTH{RESET_LEVEL}}.
  - Debounce counters, irq_mask and edge_cap go to 0, so irq=0.
  - Reset asserted mid-debounce discards the pending count.
  - No edge is detected on the first cycle after reset, because deb equals deb_d.
- Synchronizer: two flops per bit, sync1 then sync2.
- Debounce (macro on):
  - One counter per bit, width $clog2(DEBOUNCE_CYCLES+1).
  - While sync2[i] differs from deb[i]: counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the bit still differs: deb[i] <= sync2[i] and the counter clears.
  - Any cycle with sync2[i] equal to deb[i] clears the counter.
  - A pulse shorter than DEBOUNCE_CYCLES never reaches deb.
- Edge detect:
  - deb_d <= deb each cycle.
  - rise = deb & ~deb_d; fall = ~deb & deb_d; edge selected by EDGE_TYPE.
- Edge capture: edge_cap <= (edge_cap & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] when a write hits address 3, otherwise 0.
  - A set and a clear on the same bit in the same cycle: set wins, the bit stays 1.
- Latency: an input change first sampled by sync1 at edge k sets edge_cap at edge k+2+D.
  - D = DEBOUNCE_CYCLES with the macro on, D = 0 with it off.
- Register map (write = chipselect & ~write_n):
  - 0 DATA: RO, returns deb zero-extended; writes ignored.
  - 2 IRQ_MASK: RW, WIDTH bits, reset 0.
  - 3 EDGE_CAP: write-1-to-clear; reads return edge_cap.
  - 1, 4-7: read 0; writes ignored.
- Reads have no side effects. Readdata is valid whenever address is stable; chipselect is not required for reads.
- irq = |(edge_cap & irq_mask), driven only from registers so it is glitch-free.
  - Stays high until software clears the capture bits or the mask.
  - A mask write takes effect on irq the cycle after the write edge.

Optional Feature:
- BUTTON_PIO_DEBOUNCE_EN
  - Defined: per-bit debounce counters as described above. DEBOUNCE_CYCLES applies.
  - Undefined: no counters are instantiated; deb is sync2 directly (deb = sync2, D = 0) and DEBOUNCE_CYCLES is ignored.
  - The register map and irq behaviour are identical in both builds.

Test Plan:
- Reset with in_port=8'hFF, EDGE_TYPE=1: release reset and run 10 cycles -> readdata@0=32'hFF, edge_cap=0, irq=0.
- Falling edge with the macro on, DEBOUNCE_CYCLES=4: drive in_port[2] 1->0 before edge k -> DATA bit 2 reads 0 after edge k+5; edge_cap=8'h04 after edge k+6; irq stays 0 because the mask is 0; write 8'h04 to address 2 -> irq=1 on the next cycle.
- Glitch filter, DEBOUNCE_CYCLES=4: pulse in_port[0] low for 3 cycles -> DATA stays 8'hFF, edge_cap stays 0.
- W1C: with edge_cap=8'h05 and mask=8'hFF, write 8'h01 to address 3 -> edge_cap=8'h04, irq stays 1; then write 8'h04 -> edge_cap=0, irq=0.
- Set/clear collision: schedule a new edge on bit 1 in the same cycle as a W1C write of 8'h02 -> edge_cap[1]=1, irq stays asserted.
- Macro off, EDGE_TYPE=2, reset_n pulsed mid-activity: toggle bit 7 -> capture at edge k+2 for both directions; assert reset_n=0 for one edge -> mask, capture and irq all 0 on the next cycle.
